// File: rtl/bolt_pkg.sv
// Shared types and width helper for the bolt slot arbiter.
package bolt_pkg;

  typedef enum logic {OWN_PLR = 1'b0, OWN_INV = 1'b1} owner_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} arb_st_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idxW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/first_free_enc.sv
// Lowest-set-bit encoder over the free-slot mask.
module first_free_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] freeMask,
  output logic [W-1:0] idx,
  output logic         anyFree
);

  always_comb begin
    idx     = '0;
    anyFree = |freeMask;
    for (int i = N - 1; i >= 0; i--) begin
      if (freeMask[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/bolt_slot_arbiter.sv
// Bolt slot pool: grants slots to player/invaders with quotas, cooldown and
// round-robin tie-break; frees slots on hit/border release pulses.
//
// state  | meaning
// IDLE   | game not running, pool empty, no grants
// ACTIVE | grants and releases processed every cycle
// FLUSH  | one cycle clearing all slots, counts and cooldown
module bolt_slot_arbiter
  import bolt_pkg::*;
#(
  parameter int N_SLOTS  = 8,
  parameter int PLR_MAX  = 2,
  parameter int INV_MAX  = 6,
  parameter int COOL_FRM = 3,
  localparam int SLOT_W  = idxW(N_SLOTS),
  localparam int CNT_W   = idxW(N_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable,
  input  logic               srtFrm,
  input  logic               plrReq,
  input  logic               invReq,
  input  logic [N_SLOTS-1:0] relSlot,
  output logic               plrGnt,
  output logic               invGnt,
  output logic [SLOT_W-1:0]  gntSlot,
  output logic [N_SLOTS-1:0] slotBusy,
  output logic [N_SLOTS-1:0] slotOwner,
  output logic [CNT_W-1:0]   plrCnt,
  output logic [CNT_W-1:0]   invCnt
);

  localparam int               COOL_W  = idxW(COOL_FRM + 1);
  localparam logic [CNT_W-1:0] PLR_LIM = CNT_W'(PLR_MAX);
  localparam logic [CNT_W-1:0] INV_LIM = CNT_W'(INV_MAX);

  arb_st_t             state;
  owner_t              rrSide;
  logic [COOL_W-1:0]   coolCnt;
  logic [SLOT_W-1:0]   freeIdx;
  logic                anyFree;
  logic [N_SLOTS-1:0]  relEff;
  logic [N_SLOTS-1:0]  gntMask;
  logic [CNT_W-1:0]    plrRel;
  logic [CNT_W-1:0]    invRel;
  logic                plrElig;
  logic                invElig;
  logic                takePlr;
  logic                takeInv;

  // Free slots come from registered busy bits, so a slot released this
  // cycle cannot be handed out until the next one.
  first_free_enc #(.N(N_SLOTS), .W(SLOT_W)) uFirstFree (
    .freeMask (~slotBusy),
    .idx      (freeIdx),
    .anyFree  (anyFree)
  );

  always_comb begin
    relEff = relSlot & slotBusy;
    plrRel = '0;
    invRel = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (relEff[k]) begin
        if (slotOwner[k]) invRel = invRel + CNT_W'(1);
        else              plrRel = plrRel + CNT_W'(1);
      end
    end
    plrElig = (state == ACTIVE) && plrReq && (plrCnt < PLR_LIM) &&
              (coolCnt == '0) && anyFree;
    invElig = (state == ACTIVE) && invReq && (invCnt < INV_LIM) && anyFree;
    takePlr = plrElig && (!invElig || rrSide == OWN_PLR);
    takeInv = invElig && !takePlr;
    gntMask = '0;
    if (takePlr || takeInv) gntMask[freeIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      rrSide    <= OWN_PLR;
      coolCnt   <= '0;
      plrGnt    <= 1'b0;
      invGnt    <= 1'b0;
      gntSlot   <= '0;
      slotBusy  <= '0;
      slotOwner <= '0;
      plrCnt    <= '0;
      invCnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          plrGnt <= 1'b0;
          invGnt <= 1'b0;
          if (enable) state <= ACTIVE;
        end
        ACTIVE: begin
          plrGnt   <= takePlr;
          invGnt   <= takeInv;
          if (takePlr || takeInv) gntSlot <= freeIdx;
          slotBusy <= (slotBusy & ~relEff) | gntMask;
          if (takeInv) slotOwner <= slotOwner | gntMask;
          else         slotOwner <= slotOwner & ~gntMask;
          plrCnt   <= plrCnt - plrRel + CNT_W'(takePlr);
          invCnt   <= invCnt - invRel + CNT_W'(takeInv);
          if (takePlr)                         coolCnt <= COOL_W'(COOL_FRM);
          else if (srtFrm && coolCnt != '0)    coolCnt <= coolCnt - COOL_W'(1);
          if (takePlr)      rrSide <= OWN_INV;
          else if (takeInv) rrSide <= OWN_PLR;
          if (!enable) state <= FLUSH;
        end
        FLUSH: begin
          plrGnt    <= 1'b0;
          invGnt    <= 1'b0;
          slotBusy  <= '0;
          slotOwner <= '0;
          plrCnt    <= '0;
          invCnt    <= '0;
          coolCnt   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bolt_slot_arbiter.sv
// Directed bench for bolt_slot_arbiter: one instance with default cooldown,
// one with cooldown disabled, both driven by the same stimulus.
module tb_bolt_slot_arbiter;

  logic       clk = 1'b0;
  logic       resetN, enable, srtFrm, plrReq, invReq;
  logic [7:0] relSlot;

  logic       aPlrGnt, aInvGnt, bPlrGnt, bInvGnt;
  logic [2:0] aGntSlot, bGntSlot;
  logic [7:0] aBusy, aOwner, bBusy, bOwner;
  logic [3:0] aPlrCnt, aInvCnt, bPlrCnt, bInvCnt;

  int testCnt = 0;
  int failCnt = 0;

  always #5 clk = ~clk;

  bolt_slot_arbiter uDutA (
    .clk(clk), .resetN(resetN), .enable(enable), .srtFrm(srtFrm),
    .plrReq(plrReq), .invReq(invReq), .relSlot(relSlot),
    .plrGnt(aPlrGnt), .invGnt(aInvGnt), .gntSlot(aGntSlot),
    .slotBusy(aBusy), .slotOwner(aOwner), .plrCnt(aPlrCnt), .invCnt(aInvCnt)
  );

  bolt_slot_arbiter #(.COOL_FRM(0)) uDutB (
    .clk(clk), .resetN(resetN), .enable(enable), .srtFrm(srtFrm),
    .plrReq(plrReq), .invReq(invReq), .relSlot(relSlot),
    .plrGnt(bPlrGnt), .invGnt(bInvGnt), .gntSlot(bGntSlot),
    .slotBusy(bBusy), .slotOwner(bOwner), .plrCnt(bPlrCnt), .invCnt(bInvCnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetN  = 1'b0;
    enable  = 1'b0;
    srtFrm  = 1'b0;
    plrReq  = 1'b0;
    invReq  = 1'b0;
    relSlot = 8'h00;
    step();
    resetN  = 1'b1;
  endtask

  initial begin
    // 1: player grant latency and cooldown
    doReset();
    checkVal("rst_busy", 32'(aBusy), 32'h00);
    checkVal("rst_gnt", 32'({aPlrGnt, aInvGnt}), 32'h0);
    checkVal("rst_cnt", 32'({aPlrCnt, aInvCnt}), 32'h00);
    enable = 1'b1;
    plrReq = 1'b1;
    step();
    checkVal("t1_idle_nognt", 32'(aPlrGnt), 32'h0);
    step();
    checkVal("t1_gnt", 32'(aPlrGnt), 32'h1);
    checkVal("t1_slot", 32'(aGntSlot), 32'h0);
    checkVal("t1_cnt", 32'(aPlrCnt), 32'h1);
    checkVal("t1_busy", 32'(aBusy), 32'h01);
    plrReq = 1'b0;
    step();
    checkVal("t1_drop", 32'(aPlrGnt), 32'h0);
    plrReq = 1'b1;
    step();
    step();
    checkVal("t1_cool_noframe", 32'(aPlrGnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      srtFrm = 1'b1;
      step();
      srtFrm = 1'b0;
      checkVal($sformatf("t1_cool_%0d", i), 32'(aPlrGnt), 32'h0);
    end
    step();
    checkVal("t1_gnt2", 32'(aPlrGnt), 32'h1);
    checkVal("t1_slot2", 32'(aGntSlot), 32'h1);
    checkVal("t1_cnt2", 32'(aPlrCnt), 32'h2);

    // 2: invader quota and release reuse
    doReset();
    enable = 1'b1;
    invReq = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      checkVal($sformatf("t2_gnt_%0d", k), 32'(aInvGnt), 32'h1);
      checkVal($sformatf("t2_slot_%0d", k), 32'(aGntSlot), 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checkVal($sformatf("t2_stall_%0d", k), 32'(aInvGnt), 32'h0);
    end
    checkVal("t2_cnt6", 32'(aInvCnt), 32'h6);
    relSlot = 8'h04;
    step();
    relSlot = 8'h00;
    checkVal("t2_rel_nognt", 32'(aInvGnt), 32'h0);
    checkVal("t2_rel_cnt", 32'(aInvCnt), 32'h5);
    checkVal("t2_rel_busy", 32'(aBusy), 32'h3B);
    step();
    checkVal("t2_regnt", 32'(aInvGnt), 32'h1);
    checkVal("t2_regnt_slot", 32'(aGntSlot), 32'h2);
    checkVal("t2_regnt_cnt", 32'(aInvCnt), 32'h6);

    // 3: round-robin tie-break on the no-cooldown instance
    doReset();
    enable = 1'b1;
    plrReq = 1'b1;
    invReq = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      checkVal($sformatf("t3_plr_%0d", k), 32'(bPlrGnt), 32'((k % 2) == 0));
      checkVal($sformatf("t3_inv_%0d", k), 32'(bInvGnt), 32'((k % 2) == 1));
      checkVal($sformatf("t3_slot_%0d", k), 32'(bGntSlot), 32'(k));
    end
    step();
    checkVal("t3_plr_quota", 32'({bPlrGnt, bInvGnt}), 32'h1);
    checkVal("t3_plrcnt", 32'(bPlrCnt), 32'h2);
    checkVal("t3_owner", 32'(bOwner[4:0]), 32'h1A);

    // 4: full pool, release and request in the same cycle
    for (int k = 5; k < 8; k++) begin
      step();
      checkVal($sformatf("t4_fill_%0d", k), 32'(bGntSlot), 32'(k));
    end
    checkVal("t4_full", 32'(bBusy), 32'hFF);
    relSlot = 8'h20;
    step();
    relSlot = 8'h00;
    checkVal("t4_rel_nognt", 32'({bPlrGnt, bInvGnt}), 32'h0);
    checkVal("t4_rel_busy", 32'(bBusy), 32'hDF);
    checkVal("t4_rel_cnt", 32'(bInvCnt), 32'h5);
    step();
    checkVal("t4_regnt", 32'({bPlrGnt, bInvGnt}), 32'h1);
    checkVal("t4_regnt_slot", 32'(bGntSlot), 32'h5);

    // 5: enable drop flushes the pool
    enable = 1'b0;
    step();
    checkVal("t5_pre_flush_busy", 32'(bBusy), 32'hFF);
    step();
    checkVal("t5_flush_busy", 32'(bBusy), 32'h00);
    checkVal("t5_flush_cnt", 32'({bPlrCnt, bInvCnt}), 32'h00);
    for (int k = 0; k < 2; k++) begin
      step();
      checkVal($sformatf("t5_idle_nognt_%0d", k), 32'({bPlrGnt, bInvGnt}), 32'h0);
      checkVal($sformatf("t5_idle_busy_%0d", k), 32'(bBusy), 32'h00);
    end

    // 6: reset mid-game clears bolts and cooldown
    doReset();
    enable = 1'b1;
    plrReq = 1'b1;
    invReq = 1'b1;
    step();
    step();
    checkVal("t6_plr_first", 32'(aPlrGnt), 32'h1);
    plrReq = 1'b0;
    step();
    step();
    step();
    checkVal("t6_busy4", 32'(aBusy), 32'h0F);
    invReq = 1'b0;
    resetN = 1'b0;
    step();
    checkVal("t6_rst_busy", 32'(aBusy), 32'h00);
    checkVal("t6_rst_owner", 32'(aOwner), 32'h00);
    checkVal("t6_rst_cnt", 32'({aPlrCnt, aInvCnt}), 32'h00);
    checkVal("t6_rst_gnt", 32'({aPlrGnt, aInvGnt}), 32'h0);
    resetN = 1'b1;
    enable = 1'b1;
    plrReq = 1'b1;
    step();
    step();
    checkVal("t6_plr_nocool", 32'(aPlrGnt), 32'h1);
    checkVal("t6_plr_slot", 32'(aGntSlot), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
